// File: rtl/fifo_mon_pkg.sv
// Shared helpers and types for the FIFO status monitor: width derivation
// and the coarse occupancy state used for debug visibility.
package fifo_mon_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } fifo_state_e;

   // Smallest r with 2**r >= n; usable in parameter defaults.
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping storage pointer: advances on i_inc and returns to 0 after DEPTH-1.
module fifo_ptr_cnt
   import fifo_mon_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = clog2_f(DEPTH)
) (
   input  logic         clk_in,
   input  logic         areset_b,
   input  logic         i_inc,
   output logic [W-1:0] o_ptr
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   logic [W-1:0] r_ptr;

   always_ff @(posedge clk_in) begin
      if (!areset_b) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_status_monitor.sv
// FIFO control/status: gates push/pop into storage enables, owns pointers
// and occupancy, and publishes registered level, threshold and error flags.
module fifo_status_monitor
   import fifo_mon_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = clog2_f(DEPTH),
   parameter int CNT_W  = clog2_f(DEPTH + 1)
) (
   input  logic              clk_in,
   input  logic              areset_b,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic              err_clr,
   input  logic [CNT_W-1:0]  af_level,
   input  logic [CNT_W-1:0]  ae_level,
   output logic              fifo_wenable,
   output logic              fifo_renable,
   output logic [ADDR_W-1:0] write_ptr,
   output logic [ADDR_W-1:0] read_ptr,
   output logic [CNT_W-1:0]  count,
   output logic              full_ind,
   output logic              empty_ind,
   output logic              almost_full_ind,
   output logic              almost_empty_ind,
   output logic              overflow_ind,
   output logic              underflow_ind,
   output logic [CNT_W-1:0]  peak_count
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_peak;
   logic             r_full;
   logic             r_empty;
   logic             r_af;
   logic             r_ae;
   logic             r_ovf;
   logic             r_unf;

   logic             w_wen;
   logic             w_ren;
   logic             w_push_rej;
   logic             w_pop_rej;
   logic [CNT_W-1:0] w_cnt_nxt;
   fifo_state_e      w_state_nxt;

   // Enables come from registered flags only; reset forces them off.
   assign w_ren      = areset_b & pop_req & ~r_empty;
   assign w_wen      = areset_b & push_req & (~r_full | w_ren);
   assign w_push_rej = push_req & ~w_wen;
   assign w_pop_rej  = pop_req & ~w_ren;
   assign w_cnt_nxt  = r_cnt + CNT_W'(w_wen) - CNT_W'(w_ren);

   always_comb begin
      w_state_nxt = PARTIAL;
      if (w_cnt_nxt == '0) begin
         w_state_nxt = EMPTY;
      end else if (w_cnt_nxt == DEPTH_C) begin
         w_state_nxt = FULL;
      end
   end

   fifo_ptr_cnt #(.DEPTH(DEPTH), .W(ADDR_W)) u_wptr (
      .clk_in   (clk_in),
      .areset_b (areset_b),
      .i_inc    (w_wen),
      .o_ptr    (write_ptr)
   );

   fifo_ptr_cnt #(.DEPTH(DEPTH), .W(ADDR_W)) u_rptr (
      .clk_in   (clk_in),
      .areset_b (areset_b),
      .i_inc    (w_ren),
      .o_ptr    (read_ptr)
   );

   // Flags track count_next so they line up with the count they describe.
   always_ff @(posedge clk_in) begin
      if (!areset_b) begin
         r_cnt   <= '0;
         r_peak  <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_state_nxt == FULL);
         r_empty <= (w_state_nxt == EMPTY);
         r_af    <= (w_cnt_nxt >= af_level);
         r_ae    <= (w_cnt_nxt <= ae_level);

         if (w_push_rej)   r_ovf <= 1'b1;
         else if (err_clr) r_ovf <= 1'b0;

         if (w_pop_rej)    r_unf <= 1'b1;
         else if (err_clr) r_unf <= 1'b0;

         if (err_clr)                  r_peak <= w_cnt_nxt;
         else if (w_cnt_nxt > r_peak)  r_peak <= w_cnt_nxt;
      end
   end

   assign fifo_wenable     = w_wen;
   assign fifo_renable     = w_ren;
   assign count            = r_cnt;
   assign full_ind         = r_full;
   assign empty_ind        = r_empty;
   assign almost_full_ind  = r_af;
   assign almost_empty_ind = r_ae;
   assign overflow_ind     = r_ovf;
   assign underflow_ind    = r_unf;
   assign peak_count       = r_peak;

endmodule
